// File: rtl/framer_pkg.sv
// Shared types and defaults for the TX packet framer.
// The top module's optional sequence check is enabled by the macro FRAMER_SEQ_CHECK_EN.
package framer_pkg;

    localparam int unsigned BEAT_WIDTH           = 512;
    localparam int unsigned DEF_REQ_ID_WIDTH     = 32;
    localparam int unsigned DEF_BEATS_PER_PACKET = 16;
    // Wide enough for the largest supported BEATS_PER_PACKET (255).
    localparam int unsigned BEAT_CNT_WIDTH       = 8;
    localparam int unsigned PKT_CNT_WIDTH        = 32;
    localparam int unsigned ERR_CNT_WIDTH        = 16;

    typedef logic [BEAT_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        StHdr  = 2'd0,
        StData = 2'd1,
        StFtr  = 2'd2
    } frame_state_e;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc_err(
        input logic [ERR_CNT_WIDTH-1:0] value
    );
        if (value == {ERR_CNT_WIDTH{1'b1}}) begin
            return value;
        end
        return value + ERR_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tx_packet_framer.sv
// Frames the request-manager TX stream: header, fixed data beats, footer, with ID checking.
// Optional macro FRAMER_SEQ_CHECK_EN adds a header-to-header sequence check.
module tx_packet_framer
    import framer_pkg::*;
#(
    parameter int unsigned REQ_ID_WIDTH     = DEF_REQ_ID_WIDTH,
    parameter int unsigned BEATS_PER_PACKET = DEF_BEATS_PER_PACKET
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BEAT_WIDTH-1:0]    AXIS_RX_TDATA,
    input  logic                     AXIS_RX_TVALID,
    output logic                     AXIS_RX_TREADY,
    output logic [BEAT_WIDTH-1:0]    AXIS_TX_TDATA,
    output logic                     AXIS_TX_TVALID,
    output logic                     AXIS_TX_TLAST,
    output logic                     AXIS_TX_TUSER,
    input  logic                     AXIS_TX_TREADY,
    output logic [PKT_CNT_WIDTH-1:0] PKT_COUNT,
    output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT,
    output logic                     FRAME_ERR
);

    frame_state_e               state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [REQ_ID_WIDTH-1:0]    hdr_id_q, hdr_id_d;
    beat_t                      tx_data_q, tx_data_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       tx_last_q, tx_last_d;
    logic                       tx_user_q, tx_user_d;
    logic                       frame_err_q, frame_err_d;
    logic [PKT_CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

    logic                       rx_ready;
    logic                       rx_hs;
    logic                       tx_hs;
    logic [REQ_ID_WIDTH-1:0]    rx_id;
    logic                       id_mismatch;
    logic                       ftr_bad;

    assign rx_id       = AXIS_RX_TDATA[REQ_ID_WIDTH-1:0];
    assign id_mismatch = (rx_id != hdr_id_q);

    // The output stage can take a new beat when empty or when its beat leaves this cycle.
    assign rx_ready = !reset && (!tx_valid_q || AXIS_TX_TREADY);
    assign rx_hs    = AXIS_RX_TVALID && rx_ready;
    assign tx_hs    = tx_valid_q && AXIS_TX_TREADY;

`ifdef FRAMER_SEQ_CHECK_EN
    logic seq_seen_q, seq_seen_d;
    logic seq_bad_q, seq_bad_d;

    always_comb begin
        seq_seen_d = seq_seen_q;
        seq_bad_d  = seq_bad_q;
        if (rx_hs && (state_q == StHdr)) begin
            // hdr_id_q still holds the previous header here.
            seq_bad_d  = seq_seen_q && (rx_id != (hdr_id_q + REQ_ID_WIDTH'(1)));
            seq_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_seen_q <= 1'b0;
            seq_bad_q  <= 1'b0;
        end else begin
            seq_seen_q <= seq_seen_d;
            seq_bad_q  <= seq_bad_d;
        end
    end

    assign ftr_bad = id_mismatch || seq_bad_q;
`else
    assign ftr_bad = id_mismatch;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_id_d    = hdr_id_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        tx_user_d   = tx_user_q;
        frame_err_d = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (tx_hs) begin
            tx_valid_d = 1'b0;
            if (tx_last_q) begin
                pkt_cnt_d = pkt_cnt_q + PKT_CNT_WIDTH'(1);
            end
        end

        if (rx_hs) begin
            tx_data_d  = AXIS_RX_TDATA;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            tx_user_d  = 1'b0;
            unique case (state_q)
                StHdr: begin
                    hdr_id_d = rx_id;
                    cnt_d    = BEAT_CNT_WIDTH'(BEATS_PER_PACKET);
                    state_d  = StData;
                end
                StData: begin
                    cnt_d = cnt_q - BEAT_CNT_WIDTH'(1);
                    if (cnt_q == BEAT_CNT_WIDTH'(1)) begin
                        state_d = StFtr;
                    end
                end
                StFtr: begin
                    tx_last_d   = 1'b1;
                    tx_user_d   = ftr_bad;
                    frame_err_d = ftr_bad;
                    if (ftr_bad) begin
                        err_cnt_d = sat_inc_err(err_cnt_q);
                    end
                    state_d = StHdr;
                end
                default: begin
                    state_d = StHdr;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StHdr;
            cnt_q       <= '0;
            hdr_id_q    <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_user_q   <= 1'b0;
            frame_err_q <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_id_q    <= hdr_id_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            tx_user_q   <= tx_user_d;
            frame_err_q <= frame_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign AXIS_RX_TREADY = rx_ready;
    assign AXIS_TX_TDATA  = tx_data_q;
    assign AXIS_TX_TVALID = tx_valid_q;
    assign AXIS_TX_TLAST  = tx_last_q;
    assign AXIS_TX_TUSER  = tx_user_q;
    assign PKT_COUNT      = pkt_cnt_q;
    assign ERR_COUNT      = err_cnt_q;
    assign FRAME_ERR      = frame_err_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// Scoreboard bench for tx_packet_framer; expected beats are queued on RX handshake.
// Expectations follow FRAMER_SEQ_CHECK_EN when the macro is defined.
module tb_tx_packet_framer;

    localparam int unsigned BW    = 512;
    localparam int unsigned BEATS = 16;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
        logic          user;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] rx_tdata = '0;
    logic          rx_tvalid = 1'b0;
    logic          rx_tready;
    logic [BW-1:0] tx_tdata;
    logic          tx_tvalid;
    logic          tx_tlast;
    logic          tx_tuser;
    logic          tx_tready = 1'b1;
    logic [31:0]   pkt_count;
    logic [15:0]   err_count;
    logic          frame_err;

    tx_packet_framer dut (
        .clk            (clk),
        .reset          (reset),
        .AXIS_RX_TDATA  (rx_tdata),
        .AXIS_RX_TVALID (rx_tvalid),
        .AXIS_RX_TREADY (rx_tready),
        .AXIS_TX_TDATA  (tx_tdata),
        .AXIS_TX_TVALID (tx_tvalid),
        .AXIS_TX_TLAST  (tx_tlast),
        .AXIS_TX_TUSER  (tx_tuser),
        .AXIS_TX_TREADY (tx_tready),
        .PKT_COUNT      (pkt_count),
        .ERR_COUNT      (err_count),
        .FRAME_ERR      (frame_err)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            tready_mode = 0;  // 0 always, 1 toggle, 2 random
    bit            tog = 1'b0;
    bit            rand_gaps = 1'b0;
    int            exp_pkt = 0;
    int            exp_err = 0;
    int            exp_fe = 0;
    int            seen_fe = 0;
    bit            hold_pend = 1'b0;
    logic [BW-1:0] held_data;
    logic          held_last, held_user;
    bit            lat_pend = 1'b0;
    logic [BW-1:0] lat_data;
    bit            seq_seen = 1'b0;
    logic [31:0]   seq_prev = '0;

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One clock cycle: drive at negedge, check outputs, update scoreboard.
    task automatic run_cycle(input logic vld, input logic [BW-1:0] data, input logic el,
                             input logic eu, output logic acc);
        logic trdy;
        @(negedge clk);
        tog = ~tog;
        case (tready_mode)
            0:       trdy = 1'b1;
            1:       trdy = tog;
            default: trdy = 1'($urandom_range(0, 1));
        endcase
        tx_tready = trdy;
        rx_tvalid = vld;
        rx_tdata  = data;
        #1;
        if (hold_pend) begin
            n_cmp++;
            if (!tx_tvalid || tx_tdata !== held_data || tx_tlast !== held_last ||
                tx_tuser !== held_user) begin
                n_mis++;
                $display("FAIL hold_stable: valid=%b last=%b user=%b data_lo=%h need last=%b user=%b data_lo=%h",
                         tx_tvalid, tx_tlast, tx_tuser, tx_tdata[31:0], held_last, held_user,
                         held_data[31:0]);
            end
        end
        if (lat_pend) begin
            n_cmp++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== lat_data) begin
                n_mis++;
                $display("FAIL latency: valid=%b data_lo=%h need valid=1 data_lo=%h",
                         tx_tvalid, tx_tdata[31:0], lat_data[31:0]);
            end
        end
        n_cmp++;
        if (rx_tready !== (!tx_tvalid || trdy)) begin
            n_mis++;
            $display("FAIL rx_tready: got %b need %b", rx_tready, (!tx_tvalid || trdy));
        end
        if (frame_err === 1'b1) begin
            seen_fe++;
            n_cmp++;
            if (!(tx_tvalid && tx_tlast && tx_tuser)) begin
                n_mis++;
                $display("FAIL frame_err_align: valid=%b last=%b user=%b need 1/1/1",
                         tx_tvalid, tx_tlast, tx_tuser);
            end
        end
        if (tx_tvalid && trdy) begin
            exp_t e;
            n_cmp++;
            if (sb.size() == 0) begin
                n_mis++;
                $display("FAIL tx_extra: unexpected beat data_lo=%h", tx_tdata[31:0]);
            end else begin
                e = sb.pop_front();
                if (tx_tdata !== e.data || tx_tlast !== e.last || tx_tuser !== e.user) begin
                    n_mis++;
                    $display("FAIL tx_beat: data_lo=%h last=%b user=%b need data_lo=%h last=%b user=%b",
                             tx_tdata[31:0], tx_tlast, tx_tuser, e.data[31:0], e.last, e.user);
                end
                if (e.last) exp_pkt++;
            end
        end
        hold_pend = tx_tvalid && !trdy;
        held_data = tx_tdata;
        held_last = tx_tlast;
        held_user = tx_tuser;
        acc       = vld && rx_tready;
        lat_pend  = acc;
        lat_data  = data;
        if (acc) begin
            sb.push_back('{data: data, last: el, user: eu});
            if (el && eu) begin
                exp_err++;
                exp_fe++;
            end
        end
    endtask

    task automatic send_beat(input logic [BW-1:0] data, input logic el, input logic eu,
                             inout int cycles);
        logic acc;
        int   tries;
        if (rand_gaps && $urandom_range(0, 3) == 0) begin
            run_cycle(1'b0, '0, 1'b0, 1'b0, acc);
            cycles++;
        end
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 100) begin
            run_cycle(1'b1, data, el, eu, acc);
            cycles++;
            tries++;
        end
        n_cmp++;
        if (!acc) begin
            n_mis++;
            $display("FAIL rx_accept_timeout: beat not accepted in %0d cycles", tries);
        end
    endtask

    // nbeats data beats (< BEATS truncates the packet, footer then skipped).
    task automatic send_packet(input logic [31:0] id_h, input logic [31:0] id_f,
                               input int nbeats, output int cycles);
        logic [BW-1:0] b;
        logic          bad;
        cycles = 0;
        bad = (id_h != id_f);
`ifdef FRAMER_SEQ_CHECK_EN
        if (seq_seen && id_h != seq_prev + 32'd1) bad = 1'b1;
`endif
        seq_seen = 1'b1;
        seq_prev = id_h;
        b = rand_beat();
        b[31:0] = id_h;
        send_beat(b, 1'b0, 1'b0, cycles);
        for (int i = 0; i < nbeats; i++) send_beat(rand_beat(), 1'b0, 1'b0, cycles);
        if (nbeats == BEATS) begin
            b = rand_beat();
            b[31:0] = id_f;
            send_beat(b, 1'b1, bad, cycles);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while ((sb.size() != 0 || tx_tvalid) && n < 200) begin
            run_cycle(1'b0, '0, 1'b0, 1'b0, acc);
            n++;
        end
        run_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d beats never emitted, need 0", sb.size());
        end
    endtask

    task automatic check_counters(input string tag);
        n_cmp++;
        if (pkt_count !== 32'(exp_pkt) || err_count !== 16'(exp_err) || seen_fe != exp_fe) begin
            n_mis++;
            $display("FAIL counters_%s: pkt=%0d err=%0d fe=%0d need pkt=%0d err=%0d fe=%0d",
                     tag, pkt_count, err_count, seen_fe, exp_pkt, exp_err, exp_fe);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        rx_tvalid = 1'b1;
        rx_tdata  = rand_beat();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0 || tx_tuser !== 1'b0 ||
            frame_err !== 1'b0 || pkt_count !== 32'd0 || err_count !== 16'd0 ||
            rx_tready !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_state: v=%b l=%b u=%b fe=%b pkt=%0d err=%0d rdy=%b need all 0",
                     tx_tvalid, tx_tlast, tx_tuser, frame_err, pkt_count, err_count, rx_tready);
        end
        sb.delete();
        hold_pend = 1'b0;
        lat_pend  = 1'b0;
        exp_pkt = 0;
        exp_err = 0;
        exp_fe  = 0;
        seen_fe = 0;
        seq_seen = 1'b0;
        rx_tvalid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic_packet();
        int cyc;
        test_reset();
        tready_mode = 0;
        send_packet(32'h5, 32'h5, BEATS, cyc);
        n_cmp++;
        if (cyc != BEATS + 2) begin
            n_mis++;
            $display("FAIL basic_back_to_back: %0d cycles need %0d", cyc, BEATS + 2);
        end
        drain();
        check_counters("basic");
        n_cmp++;
        if (pkt_count !== 32'd1 || err_count !== 16'd0) begin
            n_mis++;
            $display("FAIL basic_abs: pkt=%0d err=%0d need 1 0", pkt_count, err_count);
        end
    endtask

    task automatic test_footer_mismatch();
        int cyc;
        test_reset();
        send_packet(32'h5, 32'h6, BEATS, cyc);
        drain();
        check_counters("mismatch");
        n_cmp++;
        if (pkt_count !== 32'd1 || err_count !== 16'd1 || seen_fe != 1) begin
            n_mis++;
            $display("FAIL mismatch_abs: pkt=%0d err=%0d fe=%0d need 1 1 1",
                     pkt_count, err_count, seen_fe);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        test_reset();
        tready_mode = 1;
        send_packet(32'h7, 32'h7, BEATS, cyc);
        drain();
        tready_mode = 0;
        check_counters("toggle");
    endtask

    task automatic test_reset_mid_packet();
        int cyc;
        test_reset();
        send_packet(32'h3, 32'h3, 7, cyc);
        test_reset();
        send_packet(32'h9, 32'h9, BEATS, cyc);
        drain();
        check_counters("midreset");
        n_cmp++;
        if (pkt_count !== 32'd1 || err_count !== 16'd0) begin
            n_mis++;
            $display("FAIL midreset_abs: pkt=%0d err=%0d need 1 0", pkt_count, err_count);
        end
    endtask

    task automatic test_seq_check();
        int cyc;
        int need_err;
        test_reset();
        send_packet(32'h1, 32'h1, BEATS, cyc);
        send_packet(32'h2, 32'h2, BEATS, cyc);
        send_packet(32'h4, 32'h4, BEATS, cyc);
        drain();
        check_counters("seq");
`ifdef FRAMER_SEQ_CHECK_EN
        need_err = 1;
`else
        need_err = 0;
`endif
        n_cmp++;
        if (err_count !== 16'(need_err) || pkt_count !== 32'd3) begin
            n_mis++;
            $display("FAIL seq_abs: err=%0d pkt=%0d need err=%0d pkt=3",
                     err_count, pkt_count, need_err);
        end
    endtask

    task automatic test_random_stall();
        int cyc;
        test_reset();
        tready_mode = 2;
        rand_gaps   = 1'b1;
        for (int p = 0; p < 6; p++) begin
            send_packet(32'h20 + 32'(p), (p % 3 == 1) ? 32'hDEAD : 32'h20 + 32'(p), BEATS, cyc);
        end
        drain();
        tready_mode = 0;
        rand_gaps   = 1'b0;
        check_counters("random");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_footer_mismatch();
        test_backpressure();
        test_reset_mid_packet();
        test_seq_check();
        test_random_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tx_packet_framer.md
TX_PACKET_FRAMER -- requirements
Module: tx_packet_framer

Interface
REQ-001 Parameter REQ_ID_WIDTH, default 32: width of the request ID carried in header and footer beats.
REQ-002 Parameter BEATS_PER_PACKET, default 16: data beats between header and footer (range 1..255).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 AXIS_RX_TDATA  input  512  packet beat from the request-manager TX stream.
REQ-006 AXIS_RX_TVALID  input  1  RX beat valid.
REQ-007 AXIS_RX_TREADY  output  1  RX beat accepted when high with TVALID.
REQ-008 AXIS_TX_TDATA  output  512  framed beat out.
REQ-009 AXIS_TX_TVALID  output  1  TX beat valid.
REQ-010 AXIS_TX_TLAST  output  1  high on the footer beat only.
REQ-011 AXIS_TX_TUSER  output  1  high on the footer beat when that packet failed a check.
REQ-012 AXIS_TX_TREADY  input  1  downstream accepts the TX beat.
REQ-013 PKT_COUNT  output  32  packets fully forwarded (footer handshaked).
REQ-014 ERR_COUNT  output  16  packets flagged bad.
REQ-015 FRAME_ERR  output  1  one-cycle pulse when a footer beat is flagged bad.

Function
REQ-016 Every RX beat is forwarded unmodified, in order, through one output register; latency is exactly 1 cycle from RX handshake to TX_TVALID.
REQ-017 AXIS_RX_TREADY = !reset && (!AXIS_TX_TVALID || AXIS_TX_TREADY); a sustained stream flows at one beat per cycle.
REQ-018 A TX beat is held stable (DATA, LAST, USER) while TVALID high and TREADY low.
REQ-019 FSM states: HDR, DATA, FTR; state advances only on an RX handshake.
REQ-020 HDR: the beat is latched as hdr_id = TDATA[REQ_ID_WIDTH-1:0], beat counter loaded with BEATS_PER_PACKET, go DATA.
REQ-021 DATA: counter decrements per beat; the beat that brings it to 0 moves to FTR.
REQ-022 FTR: the beat is forwarded with TLAST=1; TUSER=1 if TDATA[REQ_ID_WIDTH-1:0] != hdr_id; go HDR.
REQ-023 FRAME_ERR pulses and ERR_COUNT increments in the cycle the flagged footer is registered into the output stage.
REQ-024 PKT_COUNT increments on the TX handshake of a TLAST beat; wraps at 2^32.
REQ-025 ERR_COUNT saturates at 0xFFFF.
REQ-026 Header and data beats always carry TLAST=0, TUSER=0.

Reset
REQ-027 During reset: TX_TVALID=0, TLAST=0, TUSER=0, FRAME_ERR=0, counters=0, state=HDR, RX_TREADY=0.
REQ-028 Reset mid-packet discards the partial packet and any held TX beat; the next RX beat after reset is treated as a header.

Configuration
REQ-029 Macro FRAMER_SEQ_CHECK_EN: when defined, each header ID after the first since reset must equal previous hdr_id+1 (mod 2^REQ_ID_WIDTH); a violation flags that packet's footer with TUSER=1 (counted once even if footer also mismatches).
REQ-030 Without FRAMER_SEQ_CHECK_EN, no sequence state exists and only the header/footer comparison sets TUSER.

Structure
REQ-031 Shared package framer_pkg holds the FSM state enum, default REQ_ID_WIDTH and BEATS_PER_PACKET constants, and the 512-bit beat width.
REQ-032 No sub-module; output register and FSM reside in tx_packet_framer.

Verification
REQ-033 Header 0x5, 16 data beats, footer 0x5, TREADY=1 -> 18 TX beats back-to-back, TLAST only on beat 18, TUSER=0, PKT_COUNT=1.
REQ-034 Footer 0x6 after header 0x5 -> footer TUSER=1, FRAME_ERR one pulse, ERR_COUNT=1, PKT_COUNT=1.
REQ-035 TREADY toggled 1010... over one packet -> no beat lost or duplicated, data held stable while stalled, RX_TREADY low whenever held beat not accepted.
REQ-036 Reset asserted after header + 7 data beats, then a full packet with ID 0x9 -> TX shows only the 0x9 packet, TLAST on its footer, counters count from 0.
REQ-037 With FRAMER_SEQ_CHECK_EN, headers 0x1, 0x2, 0x4 with matching footers -> only third packet TUSER=1, ERR_COUNT=1; without the macro ERR_COUNT=0.
